// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and state encodings for the pipeline front registers
package pipe_ctrl_pkg;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int CTRL_W_DEF = 8;
    localparam logic [63:0] PC_INC = 64'd4;
    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2,
        FLUSHED = 2'd3
    } pipe_state_e;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones instead of wrapping
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX registers with stall/flush control and event counters
module pipe_front_regs
    import pipe_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CTRL_W   = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_Write,
    input  logic              IFID_Write,
    input  logic              MUX_Write,
    input  logic              branch_taken,
    input  logic [63:0]       branch_target,
    input  logic [31:0]       instr_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [63:0]       PC_out,
    output logic [63:0]       IF_ID_PC,
    output logic [31:0]       IF_ID_Instr,
    output logic              IF_ID_valid,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic              ID_EX_valid,
    output logic [1:0]        pipe_state,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count,
    output logic              ctrl_mismatch
);
    pipe_state_e r_state, w_state_nxt;
    logic w_adv, w_mis, w_stall;

    // disagreeing enables freeze both PC and IF/ID so they never drift apart
    assign w_adv   = PC_Write & IFID_Write;
    assign w_mis   = PC_Write ^ IFID_Write;
    assign w_stall = ~branch_taken & ~MUX_Write;
    assign pipe_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_out        <= RESET_PC;
            IF_ID_PC      <= '0;
            IF_ID_Instr   <= NOP;
            IF_ID_valid   <= 1'b0;
            ID_EX_ctrl    <= '0;
            ID_EX_valid   <= 1'b0;
            ctrl_mismatch <= 1'b0;
        end else if (branch_taken) begin
            PC_out      <= branch_target;
            IF_ID_Instr <= NOP;
            IF_ID_valid <= 1'b0;
            ID_EX_ctrl  <= '0;
            ID_EX_valid <= 1'b0;
        end else begin
            if (w_adv) begin
                PC_out      <= PC_out + PC_INC;
                IF_ID_PC    <= PC_out;
                IF_ID_Instr <= instr_in;
                IF_ID_valid <= 1'b1;
            end
            ID_EX_ctrl  <= MUX_Write ? ctrl_in : '0;
            ID_EX_valid <= MUX_Write & IF_ID_valid;
            if (w_mis)
                ctrl_mismatch <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= FILL;
        else
            r_state <= w_state_nxt;
    end

    // FILL lingers until an edge actually fetches something
    always_comb begin
        w_state_nxt = RUN;
        if (branch_taken)
            w_state_nxt = FLUSHED;
        else if (!MUX_Write)
            w_state_nxt = STALLED;
        else if (r_state == FILL && !w_adv)
            w_state_nxt = FILL;
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_count)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_taken),
        .count (flush_count)
    );
endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: scoreboard bench; a behavioural model queues expected outputs per edge
module tb_pipe_front_regs;
    localparam int W = 64 + 64 + 32 + 1 + 8 + 1 + 2 + 16 + 16 + 1;

    logic        clk = 1'b0;
    logic        reset, PC_Write, IFID_Write, MUX_Write, branch_taken;
    logic [63:0] branch_target;
    logic [31:0] instr_in;
    logic [7:0]  ctrl_in;
    logic [63:0] PC_out, IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_valid, ID_EX_valid, ctrl_mismatch;
    logic [7:0]  ID_EX_ctrl;
    logic [1:0]  pipe_state;
    logic [15:0] stall_count, flush_count;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_ifv, m_exv, m_mm;
    logic [7:0]  m_ctrl;
    logic [1:0]  m_state;
    int          m_sc, m_fc;

    always #5 clk = ~clk;

    pipe_front_regs dut (
        .clk(clk), .reset(reset), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
        .MUX_Write(MUX_Write), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_in(instr_in), .ctrl_in(ctrl_in), .PC_out(PC_out), .IF_ID_PC(IF_ID_PC),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_valid(IF_ID_valid), .ID_EX_ctrl(ID_EX_ctrl),
        .ID_EX_valid(ID_EX_valid), .pipe_state(pipe_state), .stall_count(stall_count),
        .flush_count(flush_count), .ctrl_mismatch(ctrl_mismatch)
    );

    function automatic logic [31:0] imem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    // Apply one cycle of inputs, advance the model by one edge, queue the expectation
    task automatic step(input logic rst, input logic pcw, input logic ifw, input logic muxw,
                        input logic bt, input logic [63:0] tgt, input logic [7:0] ctrl);
        logic [31:0] ins;
        ins = imem(m_pc);
        reset = rst; PC_Write = pcw; IFID_Write = ifw; MUX_Write = muxw;
        branch_taken = bt; branch_target = tgt; ctrl_in = ctrl; instr_in = ins;
        if (rst) begin
            m_pc = 64'h0; m_ifpc = 64'h0; m_instr = 32'h13; m_ifv = 0;
            m_ctrl = 0; m_exv = 0; m_state = 2'd0; m_sc = 0; m_fc = 0; m_mm = 0;
        end else if (bt) begin
            m_pc = tgt; m_instr = 32'h13; m_ifv = 0; m_ctrl = 0; m_exv = 0;
            m_state = 2'd3;
            m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
        end else begin
            m_exv  = muxw && m_ifv;
            m_ctrl = muxw ? ctrl : 8'h0;
            if (pcw && ifw) begin
                m_ifpc = m_pc; m_instr = ins; m_ifv = 1; m_pc = m_pc + 64'd4;
            end
            if (pcw != ifw) m_mm = 1;
            if (!muxw) m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
            m_state = !muxw ? 2'd2 : (m_state == 2'd0 && !(pcw && ifw)) ? 2'd0 : 2'd1;
        end
        exp_q.push_back({m_pc, m_ifpc, m_instr, m_ifv, m_ctrl, m_exv, m_state,
                         m_sc[15:0], m_fc[15:0], m_mm});
        @(negedge clk);
    endtask

    task automatic normal(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 1, 0, 64'h0, 8'($urandom));
    endtask

    // Monitor: every edge the DUT presents a new output set; pop and compare
    initial begin
        logic [W-1:0] act, exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act = {PC_out, IF_ID_PC, IF_ID_Instr, IF_ID_valid, ID_EX_ctrl, ID_EX_valid,
                       pipe_state, stall_count, flush_count, ctrl_mismatch};
                checks++;
                if (act !== exp_v) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL outputs t=%0t got=%h expected=%h", $time, act, exp_v);
                end
            end
        end
    end

    initial begin
        logic pcw, ifw, bt;
        step(1, 1, 1, 1, 1, 64'h40, 8'hAA);
        step(1, 0, 1, 0, 0, 64'h0, 8'h00);
        normal(2);
        step(0, 0, 0, 0, 0, 64'h0, 8'h5A);
        normal(3);
        step(0, 0, 0, 0, 1, 64'h100, 8'h77);
        normal(2);
        step(0, 1, 1, 1, 1, 64'h200, 8'h11);
        step(0, 1, 1, 0, 1, 64'h300, 8'h22);
        step(0, 1, 1, 0, 0, 64'h0, 8'h33);
        normal(1);
        step(0, 0, 1, 1, 0, 64'h0, 8'h44);
        normal(10);
        step(0, 1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 8'h01);
        normal(4);
        for (int i = 0; i < 3000; i++) begin
            bt  = ($urandom_range(0, 9) == 0);
            pcw = ($urandom_range(0, 5) != 0);
            ifw = ($urandom_range(0, 7) == 0) ? ~pcw : pcw;
            if (bt) ifw = pcw;
            step(($urandom_range(0, 299) == 0), pcw, ifw, ($urandom_range(0, 4) != 0), bt,
                 {$urandom, $urandom} & ~64'h3, 8'($urandom));
        end
        step(1, 1, 1, 1, 0, 64'h0, 8'h0);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 64'h0, 8'($urandom));
        step(0, 1, 1, 0, 1, 64'h500, 8'h9);
        step(1, 0, 0, 0, 1, 64'h600, 8'hFF);
        normal(5);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
